prio_req_queue_disp: RTL

- Parametrised, registered successor to the combinational 8-3 priority encoder with seven-segment output.
- Captures request pulses on N lines into sticky pending bits. Grants one index at a time through a valid/ready output register, selecting by fixed-priority or round-robin mode.
- Drives a multi-digit active-low seven-segment display of the granted index.
- Sits between board switches/buttons (or internal event lines) and the display/consumer logic.

---
 rtl/seg7_pkg.sv | 13 +
 rtl/prio_req_queue_disp_if.sv | 15 +
 rtl/seg7_dec.sv | 9 +
 rtl/prio_req_queue_disp.sv | 79 +++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low seven-segment code table {g,f,e,d,c,b,a} and nibble encoder
package seg7_pkg;
    localparam logic [6:0] seg_blank = 7'h7F;
    localparam logic [6:0] seg_codes [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        return seg_codes[nib];
    endfunction
endpackage

// File: rtl/prio_req_queue_disp_if.sv
// prio_req_queue_disp_if: request capture, grant handshake and display bundle
interface prio_req_queue_disp_if #(parameter int N = 8);
    localparam int W = $clog2(N);
    localparam int DIGITS = (W + 3) / 4;
    logic en;
    logic clr;
    logic [N-1:0] x;
    logic out_ready;
    logic out_valid;
    logic [W-1:0] out_idx;
    logic any;
    logic [7*DIGITS-1:0] hex;
    modport master(output en, clr, x, out_ready, input out_valid, out_idx, any, hex);
    modport slave(input en, clr, x, out_ready, output out_valid, out_idx, any, hex);
endinterface

// File: rtl/seg7_dec.sv
// seg7_dec: combinational nibble to active-low segment decoder
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = seg7_encode(nib);
endmodule

// File: rtl/prio_req_queue_disp.sv
// prio_req_queue_disp: sticky request capture, fixed/round-robin grant register
// with valid/ready handshake, and registered hex display of the granted index
module prio_req_queue_disp
    import seg7_pkg::*;
#(
    parameter int N = 8,
    parameter int MODE = 0
) (
    input logic clk,
    input logic rst_n,
    prio_req_queue_disp_if.slave bus
);
    localparam int W = $clog2(N);
    localparam int DIGITS = (W + 3) / 4;
    logic [N-1:0] pending;
    logic [N-1:0] taken;
    logic [W-1:0] sel;
    logic [W-1:0] c;
    logic [4*DIGITS-1:0] sel_ext;
    logic [7*DIGITS-1:0] seg;
    logic [7*DIGITS-1:0] hex_q;
    logic [W-1:0] idx_q;
    logic valid_q;
    logic load;
    logic grant;
    assign load = ~valid_q | bus.out_ready;
    assign grant = load & (|pending);
    assign taken = grant ? (N'(1) << sel) : '0;
    assign sel_ext = (4*DIGITS)'(sel);
    assign bus.out_valid = valid_q;
    assign bus.out_idx = idx_q;
    assign bus.hex = hex_q;
    assign bus.any = |pending;
    if (MODE == 0) begin : g_fixed
        always_comb begin
            sel = '0;
            c = '0;
            for (int i = 0; i < N; i++) begin
                c = W'(i);
                sel = pending[c] ? c : sel;
            end
        end
    end else begin : g_rr
        logic [W-1:0] last;
        // scan from last itself (lowest priority) down to last-1 (highest), so the nearest hit wins
        always_comb begin
            sel = last;
            c = '0;
            for (int i = N; i >= 1; i--) begin
                c = W'((int'(last) + N - i) % N);
                sel = pending[c] ? c : sel;
            end
        end
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) last <= '0;
            else if (!bus.clr && grant) last <= sel;
    end
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        seg7_dec u_dec (.nib(sel_ext[4*k +: 4]), .seg(seg[7*k +: 7]));
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending <= '0;
            valid_q <= 1'b0;
            idx_q <= '0;
            hex_q <= {DIGITS{seg_blank}};
        end else if (bus.clr) begin
            pending <= '0;
            valid_q <= 1'b0;
            hex_q <= {DIGITS{seg_blank}};
        end else begin
            pending <= (pending & ~taken) | (bus.en ? bus.x : '0);
            if (load) begin
                valid_q <= grant;
                hex_q <= grant ? seg : {DIGITS{seg_blank}};
            end
            if (grant) idx_q <= sel;
        end
endmodule
